// File: rtl/float_bcd_display.sv
// IEEE-754 single to d.ddd BCD converter for the seven-segment display stage.
// Fixed 13-cycle latency: decode, scale, ten double-dabble steps, done.
module float_bcd_display #(
  parameter int FRAC_DIGITS = 3,
  parameter int FIX_FRAC    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                fbits,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 bcd_int,
  output logic [4*FRAC_DIGITS-1:0]   bcd_frac,
  output logic                       err
);

  localparam int FixW = FIX_FRAC + 4;
  localparam int PrdW = FIX_FRAC + 10;
  localparam int BcdW = 4 * FRAC_DIGITS;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SCALE,
    CONV,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fbits_q, fbits_d;
  logic [FixW-1:0]   fix_q, fix_d;
  logic [3:0]        int_q, int_d;
  logic              err_q, err_d;
  logic [9:0]        f_q, f_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        oint_q, oint_d;
  logic [BcdW-1:0]   ofrac_q, ofrac_d;
  logic              oerr_q, oerr_d;

  logic              dec_s;
  logic [7:0]        dec_e;
  logic [23:0]       dec_mant;
  logic [7:0]        dec_sh;
  logic [FixW-1:0]   dec_fix;
  logic              dec_err;

  always_comb begin
    dec_s    = fbits_q[31];
    dec_e    = fbits_q[30:23];
    dec_mant = {1'b1, fbits_q[22:0]};
    dec_sh   = 8'(150 - FIX_FRAC) - dec_e;
    dec_fix  = '0;
    dec_err  = 1'b0;
    if (fbits_q[30:0] == 31'd0) begin
      dec_err = 1'b0;
    end else if (dec_e == 8'd0) begin
      dec_err = 1'b0;
    end else if (dec_s) begin
      dec_err = 1'b1;
    end else if (dec_e == 8'hFF || dec_e > 8'd130) begin
      dec_err = 1'b1;
    end else begin
      if (dec_sh < 8'd24) dec_fix = FixW'(dec_mant >> dec_sh);
      if (dec_fix[FixW-1:FIX_FRAC] >= 4'd10) begin
        dec_err = 1'b1;
        dec_fix = '0;
      end
    end
  end

  logic [9:0] scl_f;
  logic [3:0] scl_int;
  logic       scl_err;

  // Round-half-up of the binary fraction to thousandths.
  always_comb begin
    scl_f   = 10'((PrdW'(fix_q[FIX_FRAC-1:0]) * PrdW'(1000)
              + PrdW'(1 << (FIX_FRAC - 1))) >> FIX_FRAC);
    scl_int = fix_q[FixW-1:FIX_FRAC];
    scl_err = err_q;
    if (scl_f == 10'd1000) begin
      scl_f   = 10'd0;
      scl_int = scl_int + 4'd1;
    end
    if (scl_int == 4'd10) scl_err = 1'b1;
    if (scl_err) begin
      scl_f   = 10'd0;
      scl_int = 4'd0;
    end
  end

  logic [BcdW-1:0] stp_adj;
  logic [BcdW-1:0] stp_bcd;
  logic [9:0]      stp_f;

  always_comb begin
    stp_adj = bcd_q;
    for (int i = 0; i < FRAC_DIGITS; i++) begin
      if (stp_adj[i*4 +: 4] >= 4'd5)
        stp_adj[i*4 +: 4] = stp_adj[i*4 +: 4] + 4'd3;
    end
    stp_bcd = BcdW'({stp_adj, f_q[9]});
    stp_f   = {f_q[8:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    fbits_d = fbits_q;
    fix_d   = fix_q;
    int_d   = int_q;
    err_d   = err_q;
    f_d     = f_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    oint_d  = oint_q;
    ofrac_d = ofrac_q;
    oerr_d  = oerr_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          fbits_d = fbits;
          state_d = DECODE;
        end
      end
      DECODE: begin
        fix_d   = dec_fix;
        err_d   = dec_err;
        state_d = SCALE;
      end
      SCALE: begin
        int_d   = scl_int;
        f_d     = scl_f;
        err_d   = scl_err;
        bcd_d   = '0;
        cnt_d   = 4'd0;
        state_d = CONV;
      end
      CONV: begin
        bcd_d = stp_bcd;
        f_d   = stp_f;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          oint_d  = int_q;
          ofrac_d = stp_bcd;
          oerr_d  = err_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fbits_q <= '0;
      fix_q   <= '0;
      int_q   <= '0;
      err_q   <= 1'b0;
      f_q     <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      oint_q  <= '0;
      ofrac_q <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fbits_q <= fbits_d;
      fix_q   <= fix_d;
      int_q   <= int_d;
      err_q   <= err_d;
      f_q     <= f_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      oint_q  <= oint_d;
      ofrac_q <= ofrac_d;
      oerr_q  <= oerr_d;
    end
  end

  assign busy     = (state_q == DECODE) || (state_q == SCALE)
                    || (state_q == CONV);
  assign done     = (state_q == DONE);
  assign bcd_int  = oint_q;
  assign bcd_frac = ofrac_q;
  assign err      = oerr_q;

endmodule

// File: tb/tb_float_bcd_display.sv
// Directed bench for float_bcd_display.
// Each scenario task checks its own results inline.
module tb_float_bcd_display;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] fbits;
  logic        busy;
  logic        done;
  logic [3:0]  bcd_int;
  logic [11:0] bcd_frac;
  logic        err;

  int total = 0;
  int bad   = 0;

  float_bcd_display #(.FRAC_DIGITS(3), .FIX_FRAC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fbits    (fbits),
    .busy     (busy),
    .done     (done),
    .bcd_int  (bcd_int),
    .bcd_frac (bcd_frac),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle, scramble fbits afterwards, and return
  // the cycle index (start sample = cycle 0) in which done appears.
  task automatic run_conv(input logic [31:0] v, output int lat);
    @(posedge clk); #1;
    start = 1'b1;
    fbits = v;
    @(posedge clk); #1;
    start = 1'b0;
    fbits = $urandom;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    fbits = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, bcd_int, bcd_frac} !== 19'd0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b err=%b int=%h frac=%h want all 0",
               busy, done, err, bcd_int, bcd_frac);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_truncate;
    int lat;
    @(posedge clk); #1;
    start = 1'b1;
    fbits = 32'h3FB4FDF4;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_cycle1: got %b want 1", busy);
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 13 || busy !== 1'b0) begin
      bad++;
      $display("FAIL trunc_latency: got %0d busy=%b want 13 busy=0", lat, busy);
    end
    total++;
    if ({err, bcd_int, bcd_frac} !== {1'b0, 4'd1, 12'h414}) begin
      bad++;
      $display("FAIL trunc_1414: got err=%b %h.%h want 0 1.414",
               err, bcd_int, bcd_frac);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || bcd_frac !== 12'h414) begin
      bad++;
      $display("FAIL done_pulse: got done=%b frac=%h want 0 414", done, bcd_frac);
    end
  endtask

  task automatic test_exact;
    logic [31:0] vin  [6];
    logic [16:0] vexp [6];
    int lat;
    vin[0] = 32'h3F800000; vexp[0] = {1'b0, 4'd1, 12'h000};
    vin[1] = 32'h40200000; vexp[1] = {1'b0, 4'd2, 12'h500};
    vin[2] = 32'h3F000000; vexp[2] = {1'b0, 4'd0, 12'h500};
    vin[3] = 32'h00000000; vexp[3] = {1'b0, 4'd0, 12'h000};
    vin[4] = 32'h80000000; vexp[4] = {1'b0, 4'd0, 12'h000};
    vin[5] = 32'h40400000; vexp[5] = {1'b0, 4'd3, 12'h000};
    for (int i = 0; i < 6; i++) begin
      run_conv(vin[i], lat);
      total++;
      if (lat !== 13 || {err, bcd_int, bcd_frac} !== vexp[i]) begin
        bad++;
        $display("FAIL exact_%h: got lat=%0d err=%b %h.%h want lat=13 %h",
                 vin[i], lat, err, bcd_int, bcd_frac, vexp[i]);
      end
    end
  endtask

  task automatic test_round;
    int lat;
    run_conv(32'h3FFFFFFF, lat);
    total++;
    if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b0, 4'd2, 12'h000}) begin
      bad++;
      $display("FAIL round_carry: got lat=%0d err=%b %h.%h want 13 0 2.000",
               lat, err, bcd_int, bcd_frac);
    end
    run_conv(32'h411FFFFF, lat);
    total++;
    if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b1, 4'd0, 12'h000}) begin
      bad++;
      $display("FAIL round_to_10: got lat=%0d err=%b %h.%h want 13 1 0.000",
               lat, err, bcd_int, bcd_frac);
    end
  endtask

  task automatic test_errors;
    logic [31:0] vin [5];
    int lat;
    vin[0] = 32'h41200000;
    vin[1] = 32'hBF800000;
    vin[2] = 32'h7F800000;
    vin[3] = 32'h7FC00000;
    vin[4] = 32'h42000000;
    for (int i = 0; i < 5; i++) begin
      run_conv(vin[i], lat);
      total++;
      if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b1, 4'd0, 12'h000}) begin
        bad++;
        $display("FAIL err_%h: got lat=%0d err=%b %h.%h want 13 1 0.000",
                 vin[i], lat, err, bcd_int, bcd_frac);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    run_conv(32'h3FC00000, lat);
    total++;
    if ({err, bcd_int, bcd_frac} !== {1'b0, 4'd1, 12'h500}) begin
      bad++;
      $display("FAIL pre_reset_1500: got err=%b %h.%h want 0 1.500",
               err, bcd_int, bcd_frac);
    end
    @(posedge clk); #1;
    start = 1'b1;
    fbits = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({busy, done, err, bcd_int, bcd_frac} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b err=%b %h.%h want all 0",
               busy, done, err, bcd_int, bcd_frac);
    end
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_abort: got %0d active cycles want 0", seen);
    end
    run_conv(32'h40000000, lat);
    total++;
    if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b0, 4'd2, 12'h000}) begin
      bad++;
      $display("FAIL after_reset_2000: got lat=%0d err=%b %h.%h want 13 0 2.000",
               lat, err, bcd_int, bcd_frac);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    start = 1'b1;
    fbits = 32'h40400000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      lat = 1;
      while (!done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b0, 4'd3, 12'h000}) begin
        bad++;
        $display("FAIL b2b_%0d: got lat=%0d err=%b %h.%h want 13 0 3.000",
                 k, lat, err, bcd_int, bcd_frac);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(posedge clk); #1;
    start = 1'b1;
    fbits = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1;
    fbits = 32'h40400000;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 13 || {err, bcd_int, bcd_frac} !== {1'b0, 4'd1, 12'h000}) begin
      bad++;
      $display("FAIL busy_ignore: got lat=%0d err=%b %h.%h want 13 0 1.000",
               lat, err, bcd_int, bcd_frac);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fbits = 32'd0;
    test_reset;
    test_truncate;
    test_exact;
    test_round;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    test_busy_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
